// File: rtl/opc_sram_pkg.sv
// Shared definitions for the OPC7 32-bit to 16-bit async SRAM responder.
package opc_sram_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RD_LO,
    RD_HI,
    WR_SETUP_LO,
    WR_PULSE_LO,
    WR_HOLD_LO,
    WR_SETUP_HI,
    WR_PULSE_HI,
    WR_HOLD_HI,
    DONE
  } sram_state_t;

  localparam int WAIT_MIN = 1;
  localparam int WAIT_MAX = 15;

endpackage

// File: rtl/sram32_responder.sv
// Splits each 32-bit CPU access into two 16-bit async SRAM cycles, low half first.
// All pin outputs are registered and are derived from the next state.
module sram32_responder
  import opc_sram_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req,
  input  logic               rnw,
  input  logic [SRAM_AW-2:0] address,
  input  logic [31:0]        din,
  output logic [31:0]        dout,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_adr,
  output logic               sram_cs_b,
  output logic               sram_oe_b,
  output logic               sram_we_b,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in
);

  localparam logic [3:0] WLAST = 4'(WAIT_STATES - 1);

  sram_state_t        state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [SRAM_AW-2:0] addr_q, addr_d;
  logic [31:0]        din_q, din_d;
  logic [31:0]        dout_q, dout_d;
  logic               ready_q, ready_d;
  logic [SRAM_AW-1:0] adr_q, adr_d;
  logic               cs_b_q, cs_b_d;
  logic               oe_b_q, oe_b_d;
  logic               we_b_q, we_b_d;
  logic [15:0]        dq_out_q, dq_out_d;
  logic               dq_oe_q, dq_oe_d;
  logic               cnt_last;

  assign cnt_last = (cnt_q == WLAST);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    din_d    = din_q;
    dout_d   = dout_q;
    adr_d    = adr_q;
    dq_out_d = dq_out_q;
    case (state_q)
      IDLE: if (req) begin
        addr_d   = address;
        din_d    = din;
        cnt_d    = '0;
        adr_d    = {address, 1'b0};
        dq_out_d = din[15:0];
        state_d  = rnw ? RD_LO : WR_SETUP_LO;
      end
      RD_LO: if (cnt_last) begin
        cnt_d        = '0;
        dout_d[15:0] = sram_dq_in;
        adr_d        = {addr_q, 1'b1};
        state_d      = RD_HI;
      end else cnt_d = cnt_q + 4'd1;
      RD_HI: if (cnt_last) begin
        cnt_d         = '0;
        dout_d[31:16] = sram_dq_in;
        state_d       = DONE;
      end else cnt_d = cnt_q + 4'd1;
      WR_SETUP_LO: state_d = WR_PULSE_LO;
      WR_PULSE_LO: if (cnt_last) begin
        cnt_d   = '0;
        state_d = WR_HOLD_LO;
      end else cnt_d = cnt_q + 4'd1;
      // address and data only move once we_b has been high for a full cycle
      WR_HOLD_LO: begin
        adr_d    = {addr_q, 1'b1};
        dq_out_d = din_q[31:16];
        state_d  = WR_SETUP_HI;
      end
      WR_SETUP_HI: state_d = WR_PULSE_HI;
      WR_PULSE_HI: if (cnt_last) begin
        cnt_d   = '0;
        state_d = WR_HOLD_HI;
      end else cnt_d = cnt_q + 4'd1;
      WR_HOLD_HI: state_d = DONE;
      DONE:       state_d = IDLE;
      default:    state_d = IDLE;
    endcase

    cs_b_d  = (state_d == IDLE) || (state_d == DONE);
    oe_b_d  = !((state_d == RD_LO) || (state_d == RD_HI));
    we_b_d  = !((state_d == WR_PULSE_LO) || (state_d == WR_PULSE_HI));
    dq_oe_d = !cs_b_d && oe_b_d;
    ready_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      dout_q   <= '0;
      ready_q  <= 1'b0;
      adr_q    <= '0;
      cs_b_q   <= 1'b1;
      oe_b_q   <= 1'b1;
      we_b_q   <= 1'b1;
      dq_out_q <= '0;
      dq_oe_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      dout_q   <= dout_d;
      ready_q  <= ready_d;
      adr_q    <= adr_d;
      cs_b_q   <= cs_b_d;
      oe_b_q   <= oe_b_d;
      we_b_q   <= we_b_d;
      dq_out_q <= dq_out_d;
      dq_oe_q  <= dq_oe_d;
    end
  end

  assign dout        = dout_q;
  assign ready       = ready_q;
  assign sram_adr    = adr_q;
  assign sram_cs_b   = cs_b_q;
  assign sram_oe_b   = oe_b_q;
  assign sram_we_b   = we_b_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = dq_oe_q;

  a_no_contention: assert property (@(posedge clk) disable iff (reset)
    !(sram_dq_oe && !sram_oe_b));
  a_wait_range: assert property (@(posedge clk)
    (WAIT_STATES >= WAIT_MIN) && (WAIT_STATES <= WAIT_MAX));

endmodule

// File: tb/tb_sram32_responder.sv
// Directed bench: two responders (WAIT_STATES 1 and 3) each on a behavioural SRAM.
module tb_sram32_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req [2];
  logic        rnw [2];
  logic [16:0] address [2];
  logic [31:0] din [2];
  logic [31:0] dout [2];
  logic        ready [2];
  logic [17:0] sram_adr [2];
  logic        cs_b [2];
  logic        oe_b [2];
  logic        we_b [2];
  logic [15:0] dq_out [2];
  logic        dq_oe [2];
  logic [15:0] dq_in [2];
  logic [15:0] mem [2][262144];

  int n_cmp = 0;
  int n_err = 0;
  int contention = 0;
  int dbl_ready = 0;
  int stab_err = 0;
  int we_edges = 0;
  logic [17:0] max_adr1 = '0;
  bit loaded = 1'b0;

  always #5 clk = ~clk;

  assign dq_in[0] = mem[0][sram_adr[0]];
  assign dq_in[1] = mem[1][sram_adr[1]];

  sram32_responder #(.WAIT_STATES(1), .SRAM_AW(18)) u_w1 (
    .clk(clk), .reset(reset), .req(req[0]), .rnw(rnw[0]), .address(address[0]),
    .din(din[0]), .dout(dout[0]), .ready(ready[0]), .sram_adr(sram_adr[0]),
    .sram_cs_b(cs_b[0]), .sram_oe_b(oe_b[0]), .sram_we_b(we_b[0]),
    .sram_dq_out(dq_out[0]), .sram_dq_oe(dq_oe[0]), .sram_dq_in(dq_in[0]));

  sram32_responder #(.WAIT_STATES(3), .SRAM_AW(18)) u_w3 (
    .clk(clk), .reset(reset), .req(req[1]), .rnw(rnw[1]), .address(address[1]),
    .din(din[1]), .dout(dout[1]), .ready(ready[1]), .sram_adr(sram_adr[1]),
    .sram_cs_b(cs_b[1]), .sram_oe_b(oe_b[1]), .sram_we_b(we_b[1]),
    .sram_dq_out(dq_out[1]), .sram_dq_oe(dq_oe[1]), .sram_dq_in(dq_in[1]));

  // SRAM model plus pin-level protocol monitors, sampled mid-cycle
  logic        we_prev [2];
  logic        oe_prev [2];
  logic        rdy_prev [2];
  logic [17:0] adr_prev [2];
  logic [15:0] dq_prev [2];
  always @(negedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++) mem[0][i] = 16'h1000 + 16'(i);
      mem[0][18'h20] = 16'h5678;
      mem[0][18'h21] = 16'h1234;
      mem[0][18'hAA] = 16'hFFFF;
      mem[0][18'hAB] = 16'hFFFF;
      loaded = 1'b1;
    end
    for (int u = 0; u < 2; u++) begin
      if (reset) begin
        we_prev[u] = 1'b1; oe_prev[u] = 1'b0; rdy_prev[u] = 1'b0;
        adr_prev[u] = '0; dq_prev[u] = '0;
      end else begin
        if (dq_oe[u] && !oe_b[u]) contention++;
        if (ready[u] && rdy_prev[u]) dbl_ready++;
        if (we_b[u] !== we_prev[u]) begin
          we_edges++;
          if (sram_adr[u] != adr_prev[u] || dq_out[u] != dq_prev[u] || !dq_oe[u] || !oe_prev[u])
            stab_err++;
        end
        if (!cs_b[u] && !we_b[u] && dq_oe[u]) mem[u][sram_adr[u]] = dq_out[u];
        if (u == 1 && !cs_b[u] && sram_adr[u] > max_adr1) max_adr1 = sram_adr[u];
        we_prev[u] = we_b[u]; oe_prev[u] = dq_oe[u]; rdy_prev[u] = ready[u];
        adr_prev[u] = sram_adr[u]; dq_prev[u] = dq_out[u];
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // Cycle 0 is the IDLE cycle in which the request is sampled.
  task automatic xact(input int u, input bit rd, input logic [16:0] a, input logic [31:0] wd,
                      output int lat, output logic [31:0] oemask, output bit we_seen);
    @(posedge clk); #1;
    req[u] = 1'b1; rnw[u] = rd; address[u] = a; din[u] = wd;
    lat = -1; oemask = '0; we_seen = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (!oe_b[u] && c < 32) oemask[c] = 1'b1;
      if (!we_b[u]) we_seen = 1'b1;
      if (ready[u]) begin
        lat = c;
        break;
      end
    end
    if (lat < 0) begin
      n_cmp++; n_err++;
      $display("FAIL timeout: unit %0d no ready within 100 cycles", u);
    end
  endtask

  typedef struct {
    int          u;
    bit          rd;
    logic [16:0] a;
    logic [31:0] wd;
    logic [31:0] exp_d;
    int          exp_lat;
    logic [31:0] exp_oe;
  } vec_t;

  vec_t        tbl [7];
  int          lat;
  logic [31:0] oemask;
  bit          we_seen;
  logic [31:0] last_rd [2];
  logic [31:0] sb [16];
  logic [31:0] val;
  int          nrdy, cs_act;

  initial begin
    tbl[0] = '{0, 1'b1, 17'h00010, 32'h0,        32'h12345678, 3,  32'h6};
    tbl[1] = '{0, 1'b0, 17'h00003, 32'hDEADBEEF, 32'h0,        7,  32'h0};
    tbl[2] = '{0, 1'b1, 17'h00003, 32'h0,        32'hDEADBEEF, 3,  32'h6};
    tbl[3] = '{0, 1'b0, 17'h00000, 32'hA5A55A5A, 32'h0,        7,  32'h0};
    tbl[4] = '{0, 1'b1, 17'h00000, 32'h0,        32'hA5A55A5A, 3,  32'h6};
    tbl[5] = '{1, 1'b0, 17'h1FFFF, 32'hCAFEF00D, 32'h0,        11, 32'h0};
    tbl[6] = '{1, 1'b1, 17'h1FFFF, 32'h0,        32'hCAFEF00D, 7,  32'h7E};

    for (int u = 0; u < 2; u++) begin
      req[u] = 1'b0; rnw[u] = 1'b0; address[u] = '0; din[u] = '0;
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_b", 32'(cs_b[0]), 32'd1);
    check("rst_oe_b", 32'(oe_b[0]), 32'd1);
    check("rst_we_b", 32'(we_b[0]), 32'd1);
    check("rst_dq_oe", 32'(dq_oe[0]), 32'd0);
    check("rst_ready", 32'(ready[0]), 32'd0);
    check("rst_dout", dout[0], 32'd0);
    check("rst_adr", 32'(sram_adr[0]), 32'd0);
    check("rst_dq_out", 32'(dq_out[0]), 32'd0);
    reset = 1'b0;

    // reset asserted while we_b is low in WR_PULSE_LO
    @(posedge clk); #1;
    req[0] = 1'b1; rnw[0] = 1'b0; address[0] = 17'h5; din[0] = 32'h11112222;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midwr_we_low", 32'(we_b[0]), 32'd0);
    #1 reset = 1'b1;
    #1;
    check("midwr_we_b", 32'(we_b[0]), 32'd1);
    check("midwr_dq_oe", 32'(dq_oe[0]), 32'd0);
    check("midwr_cs_b", 32'(cs_b[0]), 32'd1);
    check("midwr_ready", 32'(ready[0]), 32'd0);
    req[0] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("midwr_idle_cs", 32'(cs_b[0]), 32'd1);

    last_rd[0] = '0; last_rd[1] = '0;
    for (int i = 0; i < 7; i++) begin
      xact(tbl[i].u, tbl[i].rd, tbl[i].a, tbl[i].wd, lat, oemask, we_seen);
      check($sformatf("v%0d_lat", i), 32'(lat), 32'(tbl[i].exp_lat));
      check($sformatf("v%0d_oe", i), oemask, tbl[i].exp_oe);
      check($sformatf("v%0d_we", i), 32'(we_seen), 32'(!tbl[i].rd));
      if (tbl[i].rd) begin
        check($sformatf("v%0d_dout", i), dout[tbl[i].u], tbl[i].exp_d);
        last_rd[tbl[i].u] = tbl[i].exp_d;
      end else
        check($sformatf("v%0d_dout_hold", i), dout[tbl[i].u], last_rd[tbl[i].u]);
    end
    req[0] = 1'b0; req[1] = 1'b0;
    check("mem_w1_lo", 32'(mem[0][18'h6]), 32'hBEEF);
    check("mem_w1_hi", 32'(mem[0][18'h7]), 32'hDEAD);
    check("mem_w3_lo", 32'(mem[1][18'h3FFFE]), 32'hF00D);
    check("mem_w3_hi", 32'(mem[1][18'h3FFFF]), 32'hCAFE);
    check("w3_max_adr", 32'(max_adr1), 32'h3FFFF);

    // req dropped and address changed in cycle 1 of a read
    @(posedge clk); #1;
    req[0] = 1'b1; rnw[0] = 1'b1; address[0] = 17'h10;
    @(posedge clk); #1;
    req[0] = 1'b0; address[0] = 17'h55;
    lat = -1; nrdy = 0; cs_act = 0; val = '0;
    for (int c = 2; c <= 8; c++) begin
      @(posedge clk); #1;
      if (ready[0]) begin
        nrdy++;
        if (lat < 0) begin lat = c; val = dout[0]; end
      end
      if (c > 3 && !cs_b[0]) cs_act++;
    end
    check("drop_lat", 32'(lat), 32'd3);
    check("drop_nrdy", 32'(nrdy), 32'd1);
    check("drop_dout", val, 32'h12345678);
    check("drop_stay_idle", 32'(cs_act), 32'd0);

    // back-to-back random traffic with req held high throughout
    for (int a = 0; a < 16; a++) sb[a] = {mem[0][2*a+1], mem[0][2*a]};
    for (int i = 0; i < 100; i++) begin
      automatic bit rd = 1'($urandom_range(0, 1));
      automatic int a = int'($urandom_range(0, 15));
      automatic logic [31:0] wd = $urandom;
      xact(0, rd, 17'(a), wd, lat, oemask, we_seen);
      check($sformatf("rnd%0d_lat", i), 32'(lat), rd ? 32'd3 : 32'd7);
      if (rd) check($sformatf("rnd%0d_dout", i), dout[0], sb[a]);
      else sb[a] = wd;
    end
    req[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    check("contention", 32'(contention), 32'd0);
    check("ready_double", 32'(dbl_ready), 32'd0);
    check("we_edge_stable", 32'(stab_err), 32'd0);
    check("we_edges_seen", 32'(we_edges > 0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram32_responder.md
Name: sram32_responder

Overview:
- Bus responder between the OPC7 CPU's 32-bit memory interface and the 16-bit asynchronous external SRAM on the BlackIce board.
- Splits each 32-bit CPU access into two 16-bit SRAM cycles and drives the SRAM control, address and data-enable pins with glitch-free registered strobes.
- Returns a registered `ready`. The system top forms the CPU clock enable as `!req | ready`.
- Replaces the fixed `wegate` tie-off, so external RAM writes become functional.

Parameters:
- WAIT_STATES, 1, clk cycles OE_b or WE_b is held low per 16-bit half; legal range 1..15.
- SRAM_AW, 18, SRAM half-word address width.

Ports:
- clk  in  1  system clock (CPU clock domain)
- reset  in  1  asynchronous, active-high reset
- req  in  1  access request: (vda|vpa) & external-RAM select, held by CPU until ready
- rnw  in  1  1=read, 0=write; sampled with req in IDLE
- address  in  SRAM_AW-1  CPU word address; half-word address = {address, half}
- din  in  32  CPU write data
- dout  out  32  read data to CPU, valid while ready=1
- ready  out  1  one-cycle completion pulse
- sram_adr  out  SRAM_AW  SRAM address pins
- sram_cs_b  out  1  SRAM chip select, active-low
- sram_oe_b  out  1  SRAM output enable, active-low
- sram_we_b  out  1  SRAM write enable, active-low
- sram_dq_out  out  16  data to pad
- sram_dq_oe  out  1  pad output enable
- sram_dq_in  in  16  data from pad

Behaviour:
- All pin outputs and ready are registered; no combinational path from inputs to sram_*.
- Reset (async) values: state=IDLE, ready=0, dout=0, sram_cs_b=1, sram_oe_b=1, sram_we_b=1, sram_dq_oe=0, sram_adr=0, sram_dq_out=0.
- Half order is always low half first, then high. Low half uses sram_adr={address,0} and carries din[15:0]/dout[15:0]. High half uses {address,1} and din[31:16]/dout[31:16].
- States: IDLE, RD_LO, RD_HI, WR_SETUP_LO, WR_PULSE_LO, WR_HOLD_LO, WR_SETUP_HI, WR_PULSE_HI, WR_HOLD_HI, DONE.
- A wait counter (4 bits) counts WAIT_STATES cycles in RD_* and WR_PULSE_* states.
- IDLE: cs_b=1, oe_b=1, we_b=1, dq_oe=0.
  - req=1 & rnw=1 -> RD_LO.
  - req=1 & rnw=0 -> WR_SETUP_LO.
  - rnw and din are latched on acceptance.
- Read path:
  - RD_LO: cs_b=0, oe_b=0, lo address; WAIT_STATES cycles. On the last cycle, capture sram_dq_in into dout[15:0] -> RD_HI.
  - RD_HI: same with hi address; capture into dout[31:16] -> DONE.
  - oe_b stays low across the LO->HI address change.
- Write path: we_b=0 only in WR_PULSE_*. Address and data are stable for one full cycle before and after every we_b edge.
  - WR_SETUP_*: cs_b=0, we_b=1, dq_oe=1, data driven.
  - WR_PULSE_*: we_b=0 for WAIT_STATES cycles.
  - WR_HOLD_*: we_b=1, address and data unchanged.
  - oe_b=1 throughout writes.
- DONE: ready=1 for exactly one cycle, strobes inactive, dq_oe=0, dout held -> IDLE unconditionally.
- Latency, counting the accept cycle in IDLE as cycle 0:
  - Read: ready is high in cycle 2·WAIT_STATES+1 (W=1: cycle 3).
  - Write: ready is high in cycle 2·WAIT_STATES+5 (W=1: cycle 7).
- Back-to-back: a new request is accepted at the earliest in the IDLE cycle after DONE. There is no pipelining.
- req deasserting mid-access: ignored, and the access completes. address/din changing mid-access: ignored, because the accepted values are latched.
- Reset mid-write: we_b returns to 1 asynchronously and dq_oe drops immediately. The partially written word is undefined.
- Bus contention: dq_oe is never 1 while oe_b=0. An assertion checks this.
- dout holds the last read value until the next read completes. Writes do not change dout.

Decomposition:
- Shared package `opc_sram_pkg` holds the state enumeration and the WAIT_STATES range constants (min 1, max 15).
- No sub-module. The wait counter is inline.

Test Plan:
- Reset asserted mid-WR_PULSE_LO -> same cycle: we_b=1, dq_oe=0, cs_b=1, ready=0; after release the FSM is in IDLE.
- W=1, read addr 0x00010, SRAM model holds [0x00020]=0x5678 and [0x00021]=0x1234 -> ready in cycle 3, dout=0x12345678, oe_b low cycles 1-2, we_b never low.
- W=1, write addr 0x00003 din=0xDEADBEEF -> model gets [0x00006]=0xBEEF and [0x00007]=0xDEAD, ready in cycle 7. Checker confirms address and data stable one cycle either side of each we_b edge.
- W=3, write then read back at 0x1FFFF (top of SRAM) -> write ready at cycle 11, read ready at cycle 7 relative to its accept, dout equals the written value, sram_adr reaches 0x3FFFF.
- req dropped in cycle 1 of a read, address changed to 0x00055 -> access completes on the original address, ready pulses once, next IDLE sees req=0 and stays idle.
- 100 random back-to-back reads and writes with req held continuously -> scoreboard matches, ready is never high on two consecutive cycles, and dq_oe is never 1 while oe_b=0.
